// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Counter width able to hold 0..max_hold-1, never narrower than one bit.
    function automatic int unsigned hold_w(input int unsigned max_hold);
        return (max_hold > 2) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold timer: a down-counter loaded on grant entry. The terminal count
// (zero) marks the MAX_HOLD-th cycle of the current grant. It saturates there,
// so a competitor that shows up late preempts the owner at the next edge.
module arb_hold_timer
    import mux2_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned W = hold_w(MAX_HOLD);
    localparam logic [W-1:0] LOAD = W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    logic [W-1:0] r_cnt;

    // Reload on grant entry, count down while the grant is held, stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= LOAD;
        end else if (i_clear) begin
            r_cnt <= LOAD;
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (MAX_HOLD != 0) && (r_cnt == '0);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | nobody owns the mux; sel keeps its last value
//  GRANT_A | A owns the mux, sel = 0
//  GRANT_B | B owns the mux, sel = 1
//
// On release the owner becomes "last", so a tie goes to the other side.
// If the other side is already requesting, it gets the mux on the same edge.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy
);

    arb_state_e r_state;
    arb_state_e w_next;
    logic       r_sel;
    logic       r_last_b;
    logic       w_last_b_next;
    logic       w_expire;
    logic       w_clear;
    logic       w_enable;

    // Hold timer restarts on every grant entry and runs while a grant is held.
    assign w_clear  = (w_next != r_state) && (w_next != IDLE);
    assign w_enable = (w_next == r_state) && (r_state != IDLE);

    arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expire (w_expire)
    );

    // Next-state and last-winner decision.
    always_comb begin
        w_next        = r_state;
        w_last_b_next = r_last_b;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next = r_last_b ? GRANT_A : GRANT_B;
                end else if (req_a) begin
                    w_next = GRANT_A;
                end else if (req_b) begin
                    w_next = GRANT_B;
                end
            end
            GRANT_A: begin
                if (done_a || !req_a || (w_expire && req_b)) begin
                    w_last_b_next = 1'b0;
                    w_next        = req_b ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (done_b || !req_b || (w_expire && req_a)) begin
                    w_last_b_next = 1'b1;
                    w_next        = req_a ? GRANT_A : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, last winner and mux select; sel only moves when a grant is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;
            r_sel    <= SEL_A;
        end else begin
            r_state  <= w_next;
            r_last_b <= w_last_b_next;
            if ((w_next == GRANT_A) && (r_state != GRANT_A)) begin
                r_sel <= SEL_A;
            end else if ((w_next == GRANT_B) && (r_state != GRANT_B)) begin
                r_sel <= SEL_B;
            end
        end
    end

    assign gnt_a = (r_state == GRANT_A);
    assign gnt_b = (r_state == GRANT_B);
    assign sel   = r_sel;
    assign busy  = (r_state != IDLE);

endmodule
